// File: rtl/branch_pkg.sv
// Shared types, default geometry and PC slicing helpers for the branch
// target buffer and the direction predictor that consumes its hits.
package branch_pkg;

  localparam int PC_WIDTH    = 32;
  localparam int TABLE_WIDTH = 3;
  localparam int TAG_WIDTH   = 8;
  localparam int TABLE_SIZE  = 2 ** TABLE_WIDTH;

  // One BTB slot as seen by the lookup path.
  typedef struct packed {
    logic                 valid;
    logic [TAG_WIDTH-1:0] tag;
    logic [PC_WIDTH-1:0]  target;
  } btb_entry_t;

  // Invalidate sweep controller states.
  typedef enum logic {
    BTB_IDLE  = 1'b0,
    BTB_SWEEP = 1'b1
  } btb_state_t;

  // Word-aligned index: PC[TABLE_WIDTH+1:2]; the same slice the direction
  // predictor uses, so both tables alias identically.
  function automatic logic [TABLE_WIDTH-1:0] btb_index(input logic [PC_WIDTH-1:0] pc);
    return pc[TABLE_WIDTH+1:2];
  endfunction

  // Tag: the TAG_WIDTH bits immediately above the index.
  function automatic logic [TAG_WIDTH-1:0] btb_tag(input logic [PC_WIDTH-1:0] pc);
    return pc[TABLE_WIDTH+2+TAG_WIDTH-1:TABLE_WIDTH+2];
  endfunction

endpackage : branch_pkg

// File: rtl/btb_sweep_ctrl.sv
// Invalidate sweep controller: walks every table index once, one per cycle,
// and reports busy while doing so. A new start request during a sweep
// restarts the walk from index 0.
module btb_sweep_ctrl
  import branch_pkg::*;
#(
  parameter int idx_width = TABLE_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  output logic                 clear_en_o,
  output logic [idx_width-1:0] clear_idx_o,
  output logic                 busy_o
);

  // Last index of the table; reaching it ends the sweep instead of wrapping.
  localparam logic [idx_width-1:0] LastIdx = '1;

  btb_state_t           state_q, state_d;
  logic [idx_width-1:0] cnt_q, cnt_d;

  // State and sweep counter registers with synchronous reset.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BTB_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: start from IDLE, restart on re-trigger, exit after the last index.
  // NOTE: defaults are assigned first so no path leaves a variable unassigned
  // (which would otherwise infer a latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      BTB_IDLE: begin
        if (start_i) begin
          state_d = BTB_SWEEP;
          cnt_d   = '0;
        end
      end
      BTB_SWEEP: begin
        if (start_i) begin
          cnt_d = '0;
        end else if (cnt_q == LastIdx) begin
          state_d = BTB_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = BTB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decodes of registered state only, so busy never glitches.
  assign busy_o      = (state_q == BTB_SWEEP);
  assign clear_en_o  = busy_o;
  assign clear_idx_o = cnt_q;

endmodule : btb_sweep_ctrl

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer for the fetch stage.
// Lookup is combinational from the registered table; taken branches resolved
// in ID write their target. Invalidate clears all entries via a one-entry-
// per-cycle sweep, during which lookups miss and updates are dropped.
// Optional feature macro: BTB_BYPASS_EN -- forward a same-cycle accepted
// update to a matching lookup (write-to-read forwarding).
// tag_width/pc_width must match the branch_pkg defaults (shared entry type).
module branch_target_buffer
  import branch_pkg::*;
#(
  parameter int table_width = TABLE_WIDTH,
  parameter int tag_width   = TAG_WIDTH,
  parameter int pc_width    = PC_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  // Fetch-side lookup
  input  logic [pc_width-1:0] IF_PC,
  output logic                IF_BTBHit,
  output logic [pc_width-1:0] IF_PredictedTarget,
  // Decode-side update
  input  logic [pc_width-1:0] ID_PC,
  input  logic                ID_AttemptBranch,
  input  logic                ID_BranchTaken,
  input  logic [pc_width-1:0] ID_BranchTarget,
  // Invalidate (fence.i)
  input  logic                Invalidate,
  output logic                BTB_Busy
);

  localparam int table_size = 2 ** table_width;

  // Table storage: valid bits are reset, payload arrays are not.
  logic [table_size-1:0] valid_q;
  logic [tag_width-1:0]  tag_q    [table_size];
  logic [pc_width-1:0]   target_q [table_size];

  // Sweep controller interface.
  logic                   clear_en;
  logic [table_width-1:0] clear_idx;
  logic                   busy;

  // Lookup and write-port decodes.
  logic [table_width-1:0] if_idx;
  logic [tag_width-1:0]   if_tag;
  logic [table_width-1:0] wr_idx;
  logic [tag_width-1:0]   wr_tag;
  logic                   wr_en;
  btb_entry_t             rd_entry;
  logic                   lk_hit;
  logic [pc_width-1:0]    lk_target;

  btb_sweep_ctrl #(
    .idx_width (table_width)
  ) u_sweep (
    .clk         (clk),
    .rst         (rst),
    .start_i     (Invalidate),
    .clear_en_o  (clear_en),
    .clear_idx_o (clear_idx),
    .busy_o      (busy)
  );

  assign BTB_Busy = busy;

  assign if_idx = btb_index(IF_PC);
  assign if_tag = btb_tag(IF_PC);
  assign wr_idx = btb_index(ID_PC);
  assign wr_tag = btb_tag(ID_PC);

  // Only taken branches allocate; a sweep in progress or a same-cycle
  // invalidate request takes priority and drops the update.
  assign wr_en = ID_AttemptBranch && ID_BranchTaken && !busy && !Invalidate;

  // Valid bits: reset clears all, the sweep clears one per cycle, updates set.
  // Sweep clear and update are mutually exclusive since wr_en requires !busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (clear_en) begin
        valid_q[clear_idx] <= 1'b0;
      end
      if (wr_en) begin
        valid_q[wr_idx] <= 1'b1;
      end
    end
  end

  // Tag/target payload write port.
  // NOTE: the payload arrays are deliberately left out of reset; an entry is
  // only ever consumed when its valid bit is set, so reset logic on them
  // would buy nothing and block RAM inference.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= ID_BranchTarget;
    end
  end

  // Read the indexed entry and compare its tag against the fetch PC.
  always_comb begin
    rd_entry        = '0;
    rd_entry.valid  = valid_q[if_idx];
    rd_entry.tag    = tag_q[if_idx];
    rd_entry.target = target_q[if_idx];
    lk_hit          = rd_entry.valid && (rd_entry.tag == if_tag) && !busy;
    lk_target       = rd_entry.target;
`ifdef BTB_BYPASS_EN
    // Forward an update accepted this cycle to a lookup of the same PC slot.
    if (wr_en && (wr_idx == if_idx) && (wr_tag == if_tag)) begin
      lk_hit    = 1'b1;
      lk_target = ID_BranchTarget;
    end
`endif
  end

  // Miss returns zero so downstream muxing never sees stale targets.
  assign IF_BTBHit          = lk_hit;
  assign IF_PredictedTarget = lk_hit ? lk_target : '0;

endmodule : branch_target_buffer
